// File: rtl/key_entry_if.sv
// Key-entry handshake bundle: switch input, presented key, downstream verdict and
// limiter status. slave = conditioner side, master = switch/downstream side.
interface key_entry_if;
  logic       ena;
  logic [7:0] sw_in;
  logic [7:0] key_out;
  logic       key_valid;
  logic       key_ready;
  logic       auth_done;
  logic       auth_pass;
  logic       locked_out;
  logic [3:0] fail_count;

  modport master (
    output ena, sw_in, key_ready, auth_done, auth_pass,
    input  key_out, key_valid, locked_out, fail_count
  );

  modport slave (
    input  ena, sw_in, key_ready, auth_done, auth_pass,
    output key_out, key_valid, locked_out, fail_count
  );
endinterface

// File: rtl/key_entry_conditioner.sv
// Debounces DIP-switch keys, offers them downstream and limits consecutive rejections.
// Define KEY_PERMALOCK_EN to make the lockout terminal (exit only via rst_n).
//
// state    | meaning
// IDLE     | waiting for the switches to differ from the last accepted key
// SETTLE   | candidate must hold DEBOUNCE_CYCLES cycles
// PRESENT  | key_valid offered, waiting for key_ready
// AWAIT    | waiting for the downstream verdict
// COOLDOWN | attempt limiter active (timed, or terminal with KEY_PERMALOCK_EN)
module key_entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int MAX_FAILS       = 3,
  parameter int COOLDOWN_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  key_entry_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETTLE, PRESENT, AWAIT, COOLDOWN} state_t;

  localparam logic [19:0] DEB_TC   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  FAIL_MAX = 4'(MAX_FAILS);
`ifdef KEY_PERMALOCK_EN
`else
  localparam logic [19:0] COOL_LOAD = 20'(COOLDOWN_CYCLES - 1);
`endif

  state_t      state, state_nxt;
  logic [7:0]  sync1, sample;
  logic [7:0]  candidate, cand_nxt;
  logic [7:0]  key_q, key_nxt;
  logic [7:0]  last_key, last_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [3:0]  fail_q, fail_nxt, fail_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (bus.ena) state <= state_nxt;
  end

  // ena low freezes every register, which also masks key_ready and auth_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sample    <= '0;
      candidate <= '0;
      key_q     <= '0;
      last_key  <= '0;
      cnt       <= '0;
      fail_q    <= '0;
    end else if (bus.ena) begin
      sync1     <= bus.sw_in;
      sample    <= sync1;
      candidate <= cand_nxt;
      key_q     <= key_nxt;
      last_key  <= last_nxt;
      cnt       <= cnt_nxt;
      fail_q    <= fail_nxt;
    end
  end

  assign fail_inc = (fail_q < FAIL_MAX) ? fail_q + 4'd1 : fail_q;

  always_comb begin
    state_nxt = state;
    cand_nxt  = candidate;
    key_nxt   = key_q;
    last_nxt  = last_key;
    cnt_nxt   = cnt;
    fail_nxt  = fail_q;
    case (state)
      IDLE: begin
        if (sample != last_key) begin
          cand_nxt  = sample;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (sample != candidate) begin
          cand_nxt = sample;
          cnt_nxt  = '0;
        end else if (cnt == DEB_TC) begin
          key_nxt   = candidate;
          cnt_nxt   = '0;
          state_nxt = PRESENT;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      PRESENT: begin
        if (bus.key_ready) begin
          last_nxt  = key_q;
          state_nxt = AWAIT;
        end
      end
      AWAIT: begin
        if (bus.auth_done) begin
          if (bus.auth_pass) begin
            fail_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            fail_nxt = fail_inc;
            if (fail_inc == FAIL_MAX) begin
              state_nxt = COOLDOWN;
`ifdef KEY_PERMALOCK_EN
              cnt_nxt = '0;
`else
              cnt_nxt = COOL_LOAD;
`endif
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      COOLDOWN: begin
`ifdef KEY_PERMALOCK_EN
        state_nxt = COOLDOWN;
`else
        if (cnt == '0) begin
          fail_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 20'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.key_out    = key_q;
  assign bus.key_valid  = (state == PRESENT) && bus.ena;
  assign bus.locked_out = (state == COOLDOWN);
  assign bus.fail_count = fail_q;

endmodule

// File: tb/tb_key_entry_conditioner.sv
// Scoreboard bench for key_entry_conditioner (DEBOUNCE 4, MAX_FAILS 3, COOLDOWN 16):
// stimulus pushes expected presentations / status changes, a monitor pops and compares.
module tb_key_entry_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_entry_if bus();

  key_entry_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .MAX_FAILS(3),
    .COOLDOWN_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {logic [7:0] key; int cyc;} pres_t;
  typedef struct {logic lvl; int cyc;} lock_t;

  pres_t      pres_q[$];
  lock_t      lock_q[$];
  logic [3:0] fail_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int auth_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  logic       prev_valid = 1'b0;
  logic       prev_lock = 1'b0;
  logic [3:0] prev_fail = 4'd0;
  pres_t      mp;
  lock_t      ml;
  logic [3:0] mf;

  always @(negedge clk) begin
    #1;
    if (bus.key_valid && !prev_valid) begin
      if (pres_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: key_out=%0h at cycle %0d, none expected", bus.key_out, cyc);
      end else begin
        mp = pres_q.pop_front();
        chk("present_key", int'(bus.key_out), int'(mp.key));
        chk("present_cycle", cyc, mp.cyc);
      end
    end
    if (bus.locked_out != prev_lock) begin
      if (lock_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_lock: locked_out=%0b at cycle %0d, no change expected", bus.locked_out, cyc);
      end else begin
        ml = lock_q.pop_front();
        chk("lock_level", int'(bus.locked_out), int'(ml.lvl));
        chk("lock_cycle", cyc, ml.cyc);
      end
    end
    if (bus.fail_count != prev_fail) begin
      if (fail_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_fail_count: got %0d at cycle %0d, no change expected", bus.fail_count, cyc);
      end else begin
        mf = fail_q.pop_front();
        chk("fail_count", int'(bus.fail_count), int'(mf));
      end
    end
    prev_valid = bus.key_valid;
    prev_lock  = bus.locked_out;
    prev_fail  = bus.fail_count;
  end

  // All stimulus tasks are entered and left just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(input logic [7:0] k, input int at);
    pres_t e;
    e.key = k;
    e.cyc = at;
    pres_q.push_back(e);
  endtask

  task automatic expect_lock(input logic lvl, input int at);
    lock_t e;
    e.lvl = lvl;
    e.cyc = at;
    lock_q.push_back(e);
  endtask

  task automatic set_sw(input logic [7:0] v, input bit exp_present);
    bus.sw_in = v;
    if (exp_present) expect_key(v, cyc + 7);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.key_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.key_valid) begin
      n_checks++;
      $display("FAIL wait_valid: key_valid still 0 after %0d cycles (cycle %0d)", n, cyc);
    end
  endtask

  // Called on the cycle key_valid is seen with key_ready=1.
  task automatic verdict(input bit pass, input logic [3:0] exp_fail, input bit push_fail,
                         input bit lock_exp);
    @(negedge clk);
    chk("valid_drop", int'(bus.key_valid), 0);
    auth_cyc = cyc;
    if (push_fail) fail_q.push_back(exp_fail);
    if (lock_exp) begin
      expect_lock(1'b1, cyc + 1);
`ifdef KEY_PERMALOCK_EN
`else
      expect_lock(1'b0, cyc + 17);
      fail_q.push_back(4'd0);
`endif
    end
    bus.auth_done = 1'b1;
    bus.auth_pass = pass;
    @(negedge clk);
    bus.auth_done = 1'b0;
    bus.auth_pass = 1'b0;
  endtask

  task automatic present_key(input logic [7:0] v, input bit pass, input logic [3:0] exp_fail,
                             input bit push_fail, input bit lock_exp);
    set_sw(v, 1'b1);
    wait_valid();
    verdict(pass, exp_fail, push_fail, lock_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.ena       = 1'b1;
    bus.sw_in     = 8'h00;
    bus.key_ready = 1'b1;
    bus.auth_done = 1'b0;
    bus.auth_pass = 1'b0;
    step(3);
    chk("reset_key_valid", int'(bus.key_valid), 0);
    chk("reset_key_out", int'(bus.key_out), 0);
    chk("reset_locked_out", int'(bus.locked_out), 0);
    chk("reset_fail_count", int'(bus.fail_count), 0);
    rst_n = 1'b1;
    step(3);

    // single change, then stray auth_done in IDLE must not count
    present_key(8'hB6, 1'b1, 4'd0, 1'b0, 1'b0);
    bus.auth_done = 1'b1;
    bus.auth_pass = 1'b0;
    step(1);
    bus.auth_done = 1'b0;
    step(2);

    // bouncing switches: only the final held value is presented
    for (int k = 0; k <= 10; k++) begin
      set_sw((k % 2 == 0) ? 8'hB7 : 8'hB6, k == 10);
      if (k < 10) step(2);
    end
    wait_valid();
    verdict(1'b1, 4'd0, 1'b0, 1'b0);

    // two rejections then a pass
    present_key(8'h11, 1'b0, 4'd1, 1'b1, 1'b0);
    present_key(8'h22, 1'b0, 4'd2, 1'b1, 1'b0);
    present_key(8'hB6, 1'b1, 4'd0, 1'b1, 1'b0);

    // three rejections -> lockout
    present_key(8'h11, 1'b0, 4'd1, 1'b1, 1'b0);
    present_key(8'h22, 1'b0, 4'd2, 1'b1, 1'b0);
    present_key(8'h33, 1'b0, 4'd3, 1'b1, 1'b1);
`ifdef KEY_PERMALOCK_EN
    set_sw(8'h44, 1'b0);
    step(1000);
    chk("permalock_held", int'(bus.locked_out), 1);
    chk("permalock_fail_count", int'(bus.fail_count), 3);
    expect_lock(1'b0, cyc);
    fail_q.push_back(4'd0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    expect_key(8'h44, cyc + 7);
    wait_valid();
    verdict(1'b1, 4'd0, 1'b0, 1'b0);
`else
    // switch change during lockout is held off until the cooldown ends
    set_sw(8'h44, 1'b0);
    expect_key(8'h44, auth_cyc + 22);
    wait_valid();
    verdict(1'b1, 4'd0, 1'b0, 1'b0);
`endif

    // ena low for 10 cycles mid-debounce stretches latency by 10
    c = cyc;
    set_sw(8'h5A, 1'b0);
    expect_key(8'h5A, c + 17);
    step(4);
    bus.ena = 1'b0;
    step(10);
    bus.ena = 1'b1;
    wait_valid();
    verdict(1'b1, 4'd0, 1'b0, 1'b0);

    // reset while presenting aborts; key re-debounced after release
    bus.key_ready = 1'b0;
    set_sw(8'hB6, 1'b1);
    wait_valid();
    step(2);
    chk("present_hold_valid", int'(bus.key_valid), 1);
    chk("present_hold_key", int'(bus.key_out), 8'hB6);
    rst_n = 1'b0;
    #1;
    chk("abort_key_valid", int'(bus.key_valid), 0);
    chk("abort_key_out", int'(bus.key_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_key(8'hB6, cyc + 7);
    wait_valid();
    bus.key_ready = 1'b1;
    verdict(1'b1, 4'd0, 1'b0, 1'b0);

    step(10);
    chk("pres_q_drained", pres_q.size(), 0);
    chk("lock_q_drained", lock_q.size(), 0);
    chk("fail_q_drained", fail_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
